// File: rtl/gates_resp_checker.sv
// Exhaustive stimulus sweeper and response checker for a combinational two-input gates unit.
// It drives every {a,b} pair, waits SETTLE cycles, then compares z_in against the selected bitwise function.
module gates_resp_checker #(
  parameter int WIDTH  = 7,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op_sel,
  output logic [WIDTH-1:0]  a_out,
  output logic [WIDTH-1:0]  b_out,
  input  logic [WIDTH-1:0]  z_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WIDTH-1:0]  first_err_a,
  output logic [WIDTH-1:0]  first_err_b,
  output logic [WIDTH-1:0]  first_err_z
);

  localparam int IDX_W = 2 * WIDTH;
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [WIDTH-1:0] fa_q, fa_d;
  logic [WIDTH-1:0] fb_q, fb_d;
  logic [WIDTH-1:0] fz_q, fz_d;
  logic [WIDTH-1:0] model_z;

  // Expected response for the op latched at start; ops 6 and 7 look at a only.
  always_comb begin
    model_z = a_out;
    case (op_q)
      3'd0:    model_z = a_out & b_out;
      3'd1:    model_z = a_out | b_out;
      3'd2:    model_z = ~(a_out & b_out);
      3'd3:    model_z = ~(a_out | b_out);
      3'd4:    model_z = a_out ^ b_out;
      3'd5:    model_z = ~(a_out ^ b_out);
      3'd6:    model_z = ~a_out;
      default: model_z = a_out;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    err_d   = err_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fz_d    = fz_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          op_d    = op_sel;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          fa_d    = '0;
          fb_d    = '0;
          fz_d    = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_CNT) begin
          if (z_in != model_z) begin
            if (err_q != '1) begin
              err_d = err_q + ERR_W'(1);
            end
            if (err_q == '0) begin
              fa_d = a_out;
              fb_d = b_out;
              fz_d = z_in;
            end
          end
          // The last vector stays on a_out/b_out while DONE.
          if (idx_q == '1) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      err_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      fz_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      err_q   <= err_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fz_q    <= fz_d;
    end
  end

  assign a_out       = idx_q[IDX_W-1:WIDTH];
  assign b_out       = idx_q[WIDTH-1:0];
  assign busy        = (state_q == ST_SETTLE);
  assign done        = (state_q == ST_DONE);
  assign pass        = (state_q == ST_DONE) && (err_q == '0);
  assign err_cnt     = err_q;
  assign first_err_a = fa_q;
  assign first_err_b = fb_q;
  assign first_err_z = fz_q;

endmodule

// File: tb/tb_gates_resp_checker.sv
// Bench for gates_resp_checker: a configurable (optionally faulty) gates unit, a cycle-count based
// reference model of the sweep, a per-cycle compare process and directed plus randomized sweeps.
module tb_gates_resp_checker;

  localparam int W      = 4;
  localparam int S      = 2;
  localparam int EW     = 7;
  localparam int NVEC   = 1 << (2 * W);
  localparam int SWEEP  = NVEC * (S + 1);
  localparam int ERRMAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    opSel;
  logic [W-1:0]  aOut, bOut, zIn;
  logic          busy, done, pass;
  logic [EW-1:0] errCnt;
  logic [W-1:0]  firstA, firstB, firstZ;

  logic [2:0]    unitOp;
  logic [W-1:0]  stuckMask;
  logic [W-1:0]  flipTable [NVEC];

  int checks = 0;
  int errors = 0;
  int busyCycles = 0;

  bit           mActive = 1'b0;
  bit           mDone = 1'b0;
  int           mK = 0;
  logic [2:0]   mOp = 3'd0;
  int           prefix [NVEC+1];
  int           firstIdx = -1;
  logic [W-1:0] firstZVal = '0;

  gates_resp_checker #(.WIDTH(W), .SETTLE(S), .ERR_W(EW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op_sel      (opSel),
    .a_out       (aOut),
    .b_out       (bOut),
    .z_in        (zIn),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_cnt     (errCnt),
    .first_err_a (firstA),
    .first_err_b (firstB),
    .first_err_z (firstZ)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gateFn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  function automatic int satCnt(input int x);
    return (x > ERRMAX) ? ERRMAX : x;
  endfunction

  // The unit under test: a chosen gate with optional stuck-at-0 bits and per-vector corruption.
  always_comb zIn = (gateFn(unitOp, aOut, bOut) & ~stuckMask) ^ flipTable[{aOut, bOut}];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Sweep model: cycles since the accepted start decide which vector is driven and how many have been judged.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mActive = 1'b0;
      mDone   = 1'b0;
      mK      = 0;
    end else if (mActive) begin
      if (mK == SWEEP) begin
        mActive = 1'b0;
        mDone   = 1'b1;
      end else begin
        mK++;
      end
    end else if (start) begin
      mOp       = opSel;
      firstIdx  = -1;
      firstZVal = '0;
      prefix[0] = 0;
      for (int i = 0; i < NVEC; i++) begin
        logic [2*W-1:0] v;
        logic [W-1:0]   zU;
        v  = i[2*W-1:0];
        zU = (gateFn(unitOp, v[2*W-1:W], v[W-1:0]) & ~stuckMask) ^ flipTable[i];
        prefix[i+1] = prefix[i];
        if (zU != gateFn(mOp, v[2*W-1:W], v[W-1:0])) begin
          prefix[i+1] = prefix[i] + 1;
          if (firstIdx < 0) begin
            firstIdx  = i;
            firstZVal = zU;
          end
        end
      end
      mActive = 1'b1;
      mDone   = 1'b0;
      mK      = 1;
    end
  end

  always @(negedge clk) begin
    if (busy === 1'b1) busyCycles++;
  end

  always @(negedge clk) begin
    int comp;
    int vidx;
    int eErr;
    bit live;
    bit fValid;
    live = mActive || mDone;
    if (mActive) begin
      comp = (mK - 1) / (S + 1);
      vidx = comp;
    end else if (mDone) begin
      comp = NVEC;
      vidx = NVEC - 1;
    end else begin
      comp = 0;
      vidx = 0;
    end
    eErr   = live ? satCnt(prefix[comp]) : 0;
    fValid = live && (firstIdx >= 0) && (firstIdx < comp);
    checkOutput("busy", 32'(busy), 32'(mActive));
    checkOutput("done", 32'(done), 32'(mDone));
    checkOutput("pass", 32'(pass), 32'(mDone && eErr == 0));
    checkOutput("a_out", 32'(aOut), 32'(vidx >> W));
    checkOutput("b_out", 32'(bOut), 32'(vidx % (1 << W)));
    checkOutput("err_cnt", 32'(errCnt), 32'(eErr));
    checkOutput("first_err_a", 32'(firstA), fValid ? 32'(firstIdx >> W) : 32'd0);
    checkOutput("first_err_b", 32'(firstB), fValid ? 32'(firstIdx % (1 << W)) : 32'd0);
    checkOutput("first_err_z", 32'(firstZ), fValid ? 32'(firstZVal) : 32'd0);
  end

  task automatic applyStimulus(input logic [2:0] op);
    @(posedge clk);
    #2;
    opSel = op;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (done !== 1'b1 && n < SWEEP + 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("sweep_done", 32'(done), 32'd1);
  endtask

  task automatic setUnit(input logic [2:0] op, input logic [W-1:0] mask);
    unitOp    = op;
    stuckMask = mask;
    for (int i = 0; i < NVEC; i++) flipTable[i] = '0;
  endtask

  task automatic runDirected(input logic [2:0] op, input int expErr, input logic [W-1:0] eA,
                             input logic [W-1:0] eB, input logic [W-1:0] eZ);
    int b0;
    b0 = busyCycles;
    applyStimulus(op);
    waitDone();
    @(negedge clk);
    checkOutput("busy_cycles", 32'(busyCycles - b0), 32'd768);
    checkOutput("final_err_cnt", 32'(errCnt), 32'(expErr));
    checkOutput("final_pass", 32'(pass), 32'(expErr == 0));
    checkOutput("final_first_a", 32'(firstA), 32'(eA));
    checkOutput("final_first_b", 32'(firstB), 32'(eB));
    checkOutput("final_first_z", 32'(firstZ), 32'(eZ));
    checkOutput("final_a_out", 32'(aOut), 32'hF);
    checkOutput("final_b_out", 32'(bOut), 32'hF);
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    opSel = 3'd0;
    setUnit(3'd0, '0);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err_cnt", 32'(errCnt), 32'd0);
    checkOutput("reset_a_out", 32'(aOut), 32'd0);

    $display("[TB] correct AND unit, op AND");
    runDirected(3'd0, 0, 4'h0, 4'h0, 4'h0);

    $display("[TB] OR unit with z[0] stuck at 0, op OR (192 misses saturate at 127)");
    setUnit(3'd1, 4'b0001);
    runDirected(3'd1, 127, 4'h0, 4'h1, 4'h0);

    $display("[TB] XOR unit judged as AND (255 misses saturate at 127)");
    setUnit(3'd4, '0);
    runDirected(3'd0, 127, 4'h0, 4'h1, 4'h1);

    $display("[TB] reset in the middle of a sweep");
    setUnit(3'd0, '0);
    applyStimulus(3'd0);
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_a_out", 32'(aOut), 32'd0);
    checkOutput("abort_b_out", 32'(bOut), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    runDirected(3'd0, 0, 4'h0, 4'h0, 4'h0);

    $display("[TB] restart and op_sel change while busy are ignored");
    setUnit(3'd4, '0);
    begin
      int b0;
      b0 = busyCycles;
      applyStimulus(3'd4);
      repeat (50) @(posedge clk);
      #2;
      start = 1'b1;
      opSel = 3'd0;
      @(posedge clk);
      #2;
      start = 1'b0;
      repeat (40) @(posedge clk);
      #2 opSel = 3'd1;
      waitDone();
      @(negedge clk);
      checkOutput("ignore_busy_cycles", 32'(busyCycles - b0), 32'd768);
      checkOutput("ignore_pass", 32'(pass), 32'd1);
    end

    $display("[TB] correct NOT unit, op NOT a");
    setUnit(3'd6, '0);
    runDirected(3'd6, 0, 4'h0, 4'h0, 4'h0);

    $display("[TB] randomized sweeps");
    for (int r = 0; r < 6; r++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      setUnit(($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : op,
              ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 15)) : '0);
      for (int i = 0; i < NVEC; i++) begin
        if ($urandom_range(0, 49) == 0) flipTable[i] = W'($urandom_range(1, 15));
      end
      repeat ($urandom_range(0, 5)) @(posedge clk);
      applyStimulus(op);
      repeat ($urandom_range(5, 300)) @(posedge clk);
      #2;
      start = 1'b1;
      opSel = 3'($urandom_range(0, 7));
      @(posedge clk);
      #2 start = 1'b0;
      waitDone();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
